// File: rtl/fractal_sync_remote_rf_sched.sv
// fractal_sync_remote_rf_sched: round-robin scheduling of sync checks onto remote RF ports with verdict routing
module fractal_sync_remote_rf_sched #(
   parameter int LEVEL_WIDTH = 1,
   parameter int ID_WIDTH    = 1,
   parameter int N_REQ       = 4,
   parameter int N_PORTS     = 2,
   parameter int IDX_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           en_i,
   input  logic [N_REQ-1:0]               req_valid_i,
   output logic [N_REQ-1:0]               req_ready_o,
   input  logic [N_REQ*LEVEL_WIDTH-1:0]   req_level_i,
   input  logic [N_REQ*ID_WIDTH-1:0]      req_id_i,
   output logic [N_PORTS*LEVEL_WIDTH-1:0] rf_level_o,
   output logic [N_PORTS*ID_WIDTH-1:0]    rf_id_o,
   output logic [N_PORTS-1:0]             rf_check_o,
   input  logic [N_PORTS-1:0]             rf_present_i,
   input  logic [N_PORTS-1:0]             rf_sig_err_i,
   input  logic [N_PORTS-1:0]             rf_bypass_i,
   input  logic [N_PORTS-1:0]             rf_ignore_i,
   output logic [N_REQ-1:0]               rsp_valid_o,
   output logic [N_REQ-1:0]               rsp_present_o,
   output logic [N_REQ-1:0]               rsp_sig_err_o,
   output logic [N_REQ-1:0]               rsp_bypass_o,
   output logic [N_REQ-1:0]               rsp_ignore_o,
   output logic                           busy_o
);
   logic [IDX_WIDTH-1:0]           rr_ptr, rr_nxt;
   logic [N_PORTS-1:0]             g_check, iss_check;
   logic [N_PORTS*LEVEL_WIDTH-1:0] g_level, iss_level;
   logic [N_PORTS*ID_WIDTH-1:0]    g_id, iss_id;
   logic [N_PORTS*IDX_WIDTH-1:0]   g_idx, iss_idx, rsp_idx;
   logic [N_PORTS-1:0]             rsp_v, rsp_pr, rsp_se, rsp_by, rsp_ig;
   // k-th granted requester (scanning from rr_ptr) lands on port k
   always_comb begin
      int cnt;
      int r;
      req_ready_o = '0;
      g_check = '0;
      g_level = '0;
      g_id = '0;
      g_idx = '0;
      rr_nxt = rr_ptr;
      cnt = 0;
      r = 0;
      for (int i = 0; i < N_REQ; i++) begin
         r = (int'(rr_ptr) + i) % N_REQ;
         if (en_i && req_valid_i[r] && cnt < N_PORTS) begin
            req_ready_o[r] = 1'b1;
            g_check[cnt] = 1'b1;
            g_level[cnt*LEVEL_WIDTH +: LEVEL_WIDTH] = req_level_i[r*LEVEL_WIDTH +: LEVEL_WIDTH];
            g_id[cnt*ID_WIDTH +: ID_WIDTH] = req_id_i[r*ID_WIDTH +: ID_WIDTH];
            g_idx[cnt*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(r);
            rr_nxt = IDX_WIDTH'((r + 1) % N_REQ);
            cnt++;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
         iss_check <= '0;
         iss_level <= '0;
         iss_id <= '0;
         iss_idx <= '0;
         rsp_v <= '0;
         rsp_idx <= '0;
         rsp_pr <= '0;
         rsp_se <= '0;
         rsp_by <= '0;
         rsp_ig <= '0;
      end else begin
         rr_ptr <= rr_nxt;
         iss_check <= g_check;
         iss_level <= g_level;
         iss_id <= g_id;
         iss_idx <= g_idx;
         rsp_v <= iss_check;
         rsp_idx <= iss_idx;
         rsp_pr <= rf_present_i & iss_check;
         rsp_se <= rf_sig_err_i & iss_check;
         rsp_by <= rf_bypass_i & iss_check;
         rsp_ig <= rf_ignore_i & iss_check;
      end
   end
   always_comb begin
      logic [IDX_WIDTH-1:0] idx;
      rsp_valid_o = '0;
      rsp_present_o = '0;
      rsp_sig_err_o = '0;
      rsp_bypass_o = '0;
      rsp_ignore_o = '0;
      idx = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         idx = rsp_idx[p*IDX_WIDTH +: IDX_WIDTH];
         if (rsp_v[p]) begin
            rsp_valid_o[idx] = 1'b1;
            rsp_present_o[idx] = rsp_pr[p];
            rsp_sig_err_o[idx] = rsp_se[p];
            rsp_bypass_o[idx] = rsp_by[p];
            rsp_ignore_o[idx] = rsp_ig[p];
         end
      end
   end
   assign rf_check_o = iss_check;
   assign rf_level_o = iss_level;
   assign rf_id_o = iss_id;
   assign busy_o = |iss_check | |rsp_v;
endmodule

// File: doc/fractal_sync_remote_rf_sched.md
Name: fractal_sync_remote_rf_sched

Overview:
- Schedules synchronization-check requests from N_REQ requesters onto the N_PORTS check ports of a 1D remote register file instance.
- Arbitrates with a rotating round-robin pointer and registers the issued checks.
- Captures the RF verdicts (present / sig_err / bypass / ignore) and routes each one back to the requester that issued it.
- Sits between the node's synchronization request queues and the remote RF, in the fractal sync tree node.

Parameters:
- LEVEL_WIDTH, 1, width of the level field.
- ID_WIDTH, 1, width of the barrier id field.
- N_REQ, 4, number of requesters; must be >= 1.
- N_PORTS, 2, number of RF check ports; must satisfy 1 <= N_PORTS <= N_REQ.
- IDX_WIDTH, max(1,$clog2(N_REQ)), width of the requester index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- en_i  in  1  scheduler enable; when low, no new grants are made.
- req_valid_i  in  N_REQ  request valid, one bit per requester.
- req_ready_o  out  N_REQ  request accepted this cycle (grant).
- req_level_i  in  N_REQ*LEVEL_WIDTH  level per requester; requester r occupies slice r.
- req_id_i  in  N_REQ*ID_WIDTH  barrier id per requester.
- rf_level_o  out  N_PORTS*LEVEL_WIDTH  level driven to RF port p.
- rf_id_o  out  N_PORTS*ID_WIDTH  id driven to RF port p.
- rf_check_o  out  N_PORTS  check strobe to RF port p.
- rf_present_i, rf_sig_err_i, rf_bypass_i, rf_ignore_i  in  N_PORTS each  RF verdicts, combinational in the same cycle as rf_check_o.
- rsp_valid_o  out  N_REQ  one-cycle response pulse per requester.
- rsp_present_o, rsp_sig_err_o, rsp_bypass_o, rsp_ignore_o  out  N_REQ each  verdict bits, qualified by rsp_valid_o.
- busy_o  out  1  any issue or response stage occupied.

Behaviour:
- Reset: synchronous; takes effect on the rising clk_i edge while rst_ni=0. After reset all outputs are 0, rr_ptr=0, and the issue and response stages are empty. This clock and reset scheme is already decided.
- Arbitration (combinational, cycle T): with en_i=1, scan requesters starting at rr_ptr, wrapping modulo N_REQ. Grant the first min(N_PORTS, #valid) requesters with req_valid_i=1. The k-th granted requester (k=0..) maps to port k. req_ready_o[r]=1 for granted r only. Handshake is valid & ready.
- rr_ptr update: if at least one grant, rr_ptr <= (index of last granted + 1) mod N_REQ; otherwise unchanged.
- Starvation: a continuously valid requester is granted within ceil(N_REQ/N_PORTS) cycles.
- en_i=0: req_ready_o=0, rr_ptr holds, and in-flight stages still drain.
- Requester obligation: req_level/req_id must be stable while valid and not ready. Dropping valid before grant is allowed; no response is produced.
- Issue stage (T+1): per port, registered {check, level, id, req_idx}. rf_check_o/level/id are driven straight from these registers. Ports with no grant have check=0, and their level/id are held at 0.
- Response stage (T+2): on the T+1 edge, capture per port {valid=check, req_idx, present, sig_err, bypass, ignore}. rsp_valid_o[req_idx]=1 and the rsp_* bits equal the captured verdicts. Total latency from accept to response is exactly 2 cycles.
- At most one port maps to a given requester per cycle, so no response collision is possible.
- Throughput: N_PORTS requests per cycle, fully pipelined, no bubbles. A requester may be re-granted in consecutive cycles.
- No backpressure on responses: requesters must sink rsp_valid_o.
- busy_o = |issue.check | |resp.valid.
- Boundary, N_PORTS == N_REQ: all valid requesters are granted every cycle and rr_ptr still updates.
- Boundary, N_REQ == 1: rr_ptr is constant 0 and IDX_WIDTH=1.
- Reset mid-operation: in-flight issue and response entries are discarded, no rsp_valid_o is emitted for them, and rf_check_o=0 from the first cycle after the reset edge.

Test Plan:
- Reset, then idle: all outputs 0 and busy_o=0. Single request r=2, level=1, id=3; RF returns present=1 -> req_ready_o=4'b0100 in cycle T; rf_check_o[0]=1 with id 3 in T+1; rsp_valid_o=4'b0100 and rsp_present_o[2]=1 in T+2.
- N_REQ=4, N_PORTS=2, all four valid continuously, rr_ptr=0 -> grants alternate {0,1},{2,3},{0,1}. Each requester gets a response every 2 cycles, each 2 cycles after its grant.
- Requesters 3 and 0 valid with rr_ptr=3 -> wrap-around: r3 goes to port 0 and r0 to port 1, then rr_ptr=1. RF bypass_i[0]=1 and ignore_i[1]=1 -> rsp_bypass_o[3]=1 and rsp_ignore_o[0]=1.
- en_i=0 with all requesters valid for 3 cycles -> no req_ready_o, rr_ptr unchanged. Responses from grants made before en_i fell still arrive 2 cycles after those grants. busy_o falls to 0 afterwards.
- Assert rst_ni=0 in the cycle after a 2-port grant -> no rsp_valid_o ever appears for it. rf_check_o=0 from the first cycle after the reset edge and rr_ptr=0.
- RF returns sig_err_i=1 on port 1 -> rsp_sig_err_o is set for the requester mapped to port 1 only, with rsp_valid_o set for both granted requesters.
